seq_pattern_tx: RTL and testbench



---
 rtl/seq_pkg.sv | 7 +
 rtl/bit_tick_gen.sv | 24 ++
 rtl/seq_pattern_tx.sv | 95 +++++++++
 tb/tb_seq_pattern_tx.sv | 134 +++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared FSM state encoding and default sizing for the serial pattern link
package seq_pkg;
  typedef enum logic [1:0] {IDLE, SEND, DONE} seq_state_t;
  localparam int PAT_W_DEF = 10;
  localparam int CNT_W_DEF = 8;
  localparam int DIV_DEF = 50000000;
endpackage

// File: rtl/bit_tick_gen.sv
// bit_tick_gen: bit-rate divider with sync clear and a registered last-cycle-of-period tick
module bit_tick_gen #(
  parameter int DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] c, c_n;
  assign c_n = (clr || c == W'(DIV - 1)) ? '0 : c + 1'b1;
  // tick is precomputed from the next count so it lines up with the last cycle of each period
  always_ff @(posedge clk) begin
    if (rst) begin
      c <= '0;
      tick <= 1'b0;
    end else begin
      c <= c_n;
      tick <= en && c_n == W'(DIV - 1);
    end
  end
endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial MSB-first pattern transmitter with repeat count; SEQ_TX_PARITY_EN appends an even-parity bit per word
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIV = DIV_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [CNT_W-1:0] rep_in,
  input  logic             stop,
  output logic             dout,
  output logic             dvalid,
  output logic             bit_tick,
  output logic             busy,
  output logic             done
);
`ifdef SEQ_TX_PARITY_EN
  localparam int K = PAT_W + 1;
`else
  localparam int K = PAT_W;
`endif
  localparam int IW = $clog2(K + 1);
  seq_state_t state;
  logic [PAT_W-1:0] pat;
  logic [CNT_W-1:0] rep;
  logic [IW-1:0] idx;
  logic cont, last, fin, send_nxt;
  function automatic logic bit_at(input logic [PAT_W-1:0] p, input logic [IW-1:0] i);
`ifdef SEQ_TX_PARITY_EN
    return i < IW'(PAT_W) ? p[PAT_W-1-int'(i)] : ^p;
`else
    return p[PAT_W-1-int'(i)];
`endif
  endfunction
  assign last = bit_tick && idx == IW'(K - 1);
  assign fin = last && (stop || (!cont && rep <= CNT_W'(1)));
  assign send_nxt = state == IDLE ? start : state == SEND && !fin;
  bit_tick_gen #(.DIV(DIV)) u_tick (
    .clk(clk),
    .rst(reset),
    .clr(state == IDLE),
    .en(send_nxt),
    .tick(bit_tick)
  );
  // transmit FSM; dout is loaded one bit ahead so every output comes straight from a flop
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pat <= '0;
      rep <= '0;
      cont <= 1'b0;
      idx <= '0;
      dout <= 1'b0;
      dvalid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= SEND;
          pat <= pat_in;
          rep <= rep_in;
          cont <= rep_in == '0;
          idx <= '0;
          dout <= pat_in[PAT_W-1];
          dvalid <= 1'b1;
          busy <= 1'b1;
        end
        SEND: if (fin) begin
          state <= DONE;
          dout <= 1'b0;
          dvalid <= 1'b0;
          done <= 1'b1;
        end else if (last) begin
          idx <= '0;
          if (!cont) rep <= rep - 1'b1;
          dout <= pat[PAT_W-1];
        end else if (bit_tick) begin
          idx <= idx + 1'b1;
          dout <= bit_at(pat, idx + 1'b1);
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: directed self-checking bench for seq_pattern_tx at DIV=2 and DIV=1
module tb_seq_pattern_tx;
`ifdef SEQ_TX_PARITY_EN
  localparam int K = 11;
`else
  localparam int K = 10;
`endif
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  logic s1, sp1, s2, sp2;
  logic [9:0] p1, p2;
  logic [7:0] r1, r2;
  logic d1_dout, d1_dvalid, d1_tick, d1_busy, d1_done;
  logic d2_dout, d2_dvalid, d2_tick, d2_busy, d2_done;
  int passed = 0;
  int total = 0;
  logic [9:0] pa, pb, pc;
  seq_pattern_tx #(.PAT_W(10), .CNT_W(8), .DIV(1)) u_d1 (
    .clk(clk), .reset(reset), .start(s1), .pat_in(p1), .rep_in(r1), .stop(sp1),
    .dout(d1_dout), .dvalid(d1_dvalid), .bit_tick(d1_tick), .busy(d1_busy), .done(d1_done)
  );
  seq_pattern_tx #(.PAT_W(10), .CNT_W(8), .DIV(2)) u_d2 (
    .clk(clk), .reset(reset), .start(s2), .pat_in(p2), .rep_in(r2), .stop(sp2),
    .dout(d2_dout), .dvalid(d2_dvalid), .bit_tick(d2_tick), .busy(d2_busy), .done(d2_done)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  function automatic logic eb(input logic [9:0] p, input int i);
    return i < 10 ? p[9-i] : ^p;
  endfunction
  task automatic step;
    @(negedge clk);
  endtask
  initial begin
    reset = 1'b1;
    {s1, sp1, s2, sp2} = '0;
    p1 = '0; p2 = '0; r1 = '0; r2 = '0;
    pa = 10'b1110010011;
    pb = 10'b1000000000;
    pc = 10'b1100110101;
    repeat (2) step;
    check("reset_d1", {d1_dout, d1_dvalid, d1_tick, d1_busy, d1_done}, 5'b0);
    check("reset_d2", {d2_dout, d2_dvalid, d2_tick, d2_busy, d2_done}, 5'b0);
    reset = 1'b0;
    step;
    check("idle_d2", {d2_dout, d2_dvalid, d2_tick, d2_busy, d2_done}, 5'b0);
    p2 = pa; r2 = 8'd1; s2 = 1'b1;
    step;
    for (int i = 0; i < 2 * K; i++) begin
      if (i == 5) begin
        s2 = 1'b1; p2 = 10'b0101010101; r2 = 8'd5;
      end else s2 = 1'b0;
      check("single_word", {d2_dout, d2_dvalid, d2_tick, d2_busy, d2_done},
            {eb(pa, i / 2), 1'b1, i % 2 == 1, 1'b1, 1'b0});
      step;
    end
    check("single_done", {d2_dout, d2_dvalid, d2_tick, d2_busy, d2_done}, 5'b00011);
    step;
    check("single_idle", {d2_dout, d2_dvalid, d2_tick, d2_busy, d2_done}, 5'b0);
    step;
    check("single_no_restart", {d2_dout, d2_dvalid, d2_tick, d2_busy, d2_done}, 5'b0);
    p1 = pb; r1 = 8'd3; s1 = 1'b1;
    step;
    s1 = 1'b0;
    for (int i = 0; i < 3 * K; i++) begin
      check("repeat", {d1_dout, d1_dvalid, d1_tick, d1_busy, d1_done},
            {eb(pb, i % K), 4'b1110});
      step;
    end
    check("repeat_done", {d1_dout, d1_dvalid, d1_tick, d1_busy, d1_done}, 5'b00011);
    step;
    check("repeat_idle", {d1_dout, d1_dvalid, d1_tick, d1_busy, d1_done}, 5'b0);
    p1 = pc; r1 = 8'd0; s1 = 1'b1;
    step;
    s1 = 1'b0;
    for (int i = 0; i < 2 * K; i++) begin
      if (i == K + 4) sp1 = 1'b1;
      check("continuous", {d1_dout, d1_dvalid, d1_tick, d1_busy, d1_done},
            {eb(pc, i % K), 4'b1110});
      step;
    end
    check("stop_done", {d1_dout, d1_dvalid, d1_tick, d1_busy, d1_done}, 5'b00011);
    step;
    check("stop_no_word3", {d1_dout, d1_dvalid, d1_tick, d1_busy, d1_done}, 5'b0);
    sp1 = 1'b0;
    p1 = pb; r1 = 8'd0; s1 = 1'b1;
    step;
    s1 = 1'b0;
    repeat (4) step;
    check("pre_reset_dvalid", d1_dvalid, 1'b1);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      check("reset_mid", {d1_dout, d1_dvalid, d1_tick, d1_busy, d1_done}, 5'b0);
    end
    reset = 1'b0;
    step;
    check("post_reset_idle", {d1_dout, d1_dvalid, d1_tick, d1_busy, d1_done}, 5'b0);
    r1 = 8'd1; s1 = 1'b1;
    step;
    s1 = 1'b0;
    for (int i = 0; i < K; i++) begin
      check("restart", {d1_dout, d1_dvalid, d1_tick, d1_busy, d1_done},
            {eb(pb, i), 4'b1110});
      step;
    end
    check("restart_done", {d1_dout, d1_dvalid, d1_tick, d1_busy, d1_done}, 5'b00011);
    step;
`ifdef SEQ_TX_PARITY_EN
    p1 = 10'b1110100110; r1 = 8'd1; s1 = 1'b1;
    step;
    s1 = 1'b0;
    repeat (10) step;
    check("parity_even_zero", {d1_dout, d1_dvalid}, 2'b01);
    step;
    check("parity_even_done", d1_done, 1'b1);
    step;
    p1 = pb; s1 = 1'b1;
    step;
    s1 = 1'b0;
    repeat (10) step;
    check("parity_odd_one", {d1_dout, d1_dvalid}, 2'b11);
    step;
    check("parity_odd_done", d1_done, 1'b1);
    step;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
